// File: rtl/qpd_pkg.sv
// Shared types and helpers for the multi-channel delay trigger generator.
package qpd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PULSE = 2'd2
  } qpd_state_t;

  localparam logic QPD_ONESHOT  = 1'b0;
  localparam logic QPD_PERIODIC = 1'b1;

  // A zero delay or width would never match a count-1 compare, so it is stored as 1.
  function automatic logic [31:0] qpd_clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/qpd_multi_if.sv
// Parameter-load port of qpd_multi: one write channel shared by all trigger channels.
// Handshake: a write is taken on a rising sclock edge where load_valid and load_ready are
// both high; load_ready reflects only whether the addressed channel is idle, never valid.
interface qpd_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PW_W   = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             load_valid;
  logic             load_ready;
  logic [CH_W-1:0]  load_ch;
  logic [CNT_W-1:0] load_delay;
  logic [PW_W-1:0]  load_pw;
  logic             load_mode;

  modport master (
    output load_valid, load_ch, load_delay, load_pw, load_mode,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_ch, load_delay, load_pw, load_mode,
    output load_ready
  );
endinterface

// File: rtl/qpd_channel.sv
// One trigger channel: parameter registers, IDLE/WAIT/PULSE FSM and shared counter.
// Optional QPD_HOLDOFF_EN raises every stored delay to at least HOLDOFF cycles.
module qpd_channel
  import qpd_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PW_W    = 8,
  parameter int HOLDOFF = 23000
) (
  input  logic             sclock,
  input  logic             rst,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_delay,
  input  logic [PW_W-1:0]  load_pw,
  input  logic             load_mode,
  input  logic             arm,
  input  logic             abort,
  output logic             trigger,
  output logic             busy,
  output logic             done,
  output qpd_state_t       state_dbg
);

  qpd_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] delay_r, d_store;
  logic [PW_W-1:0]  pw_r, p_store;
  logic             mode_r;
  logic             fresh, fresh_next;
  logic             done_r, done_next;
  logic             arm_go;

  assign p_store = PW_W'(qpd_clamp1(32'(load_pw)));

`ifdef QPD_HOLDOFF_EN
  logic [CNT_W-1:0] d_min1;
  logic             hold_clamp;
  logic             holdoff_hit;

  assign d_min1     = CNT_W'(qpd_clamp1(32'(load_delay)));
  assign hold_clamp = (d_min1 < CNT_W'(HOLDOFF));
  assign d_store    = hold_clamp ? CNT_W'(HOLDOFF) : d_min1;

  // Sticky record that some load was raised to the holdoff floor.
  always_ff @(posedge sclock or posedge rst) begin
    if (rst)                        holdoff_hit <= 1'b0;
    else if (load_en && hold_clamp) holdoff_hit <= 1'b1;
  end
`else
  assign d_store = CNT_W'(qpd_clamp1(32'(load_delay)));
`endif

  always_ff @(posedge sclock or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      delay_r <= '0;
      pw_r    <= '0;
      mode_r  <= QPD_ONESHOT;
      fresh   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      fresh  <= fresh_next;
      done_r <= done_next;
      if (load_en) begin
        delay_r <= d_store;
        pw_r    <= p_store;
        mode_r  <= load_mode;
      end
    end
  end

  // Abort beats arm; arm only counts with parameters not yet consumed.
  assign arm_go = arm & fresh & ~abort;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    fresh_next = fresh;
    case (state)
      IDLE: begin
        if (arm_go) begin
          state_next = WAIT;
          cnt_next   = '0;
          fresh_next = 1'b0;
        end
      end
      WAIT: begin
        if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == delay_r - 1'b1) begin
          state_next = PULSE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PULSE: begin
        if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(pw_r) - 1'b1) begin
          cnt_next = '0;
          if (mode_r == QPD_PERIODIC) begin
            state_next = WAIT;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // A load lands after the arm decision, so it re-arms the fresh flag.
    if (load_en) fresh_next = 1'b1;
  end

  always_comb begin
    trigger   = (state == PULSE);
    busy      = (state != IDLE);
    state_dbg = state;
  end

  assign done = done_r;

endmodule

// File: rtl/qpd_multi.sv
// Multi-channel programmable delay trigger generator (sclock domain).
// Define QPD_HOLDOFF_EN to enforce a minimum delay of HOLDOFF cycles on every channel.
module qpd_multi
  import qpd_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PW_W    = 8,
  parameter int HOLDOFF = 23000
) (
  input  logic              sclock,
  input  logic              rst,
  qpd_multi_if.slave        load,
  input  logic [NUM_CH-1:0] arm,
  input  logic [NUM_CH-1:0] abort,
  output logic [NUM_CH-1:0] trigger,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output qpd_state_t        state_dbg [NUM_CH]
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NPAD = 1 << CH_W;

  // Unpopulated channel codes read as idle; no channel matches them, so nothing is written.
  logic [NPAD-1:0] busy_pad;
  assign busy_pad        = NPAD'(busy);
  assign load.load_ready = ~busy_pad[load.load_ch];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic load_en;
    assign load_en = load.load_valid & load.load_ready & (load.load_ch == CH_W'(g));

    qpd_channel #(
      .CNT_W   (CNT_W),
      .PW_W    (PW_W),
      .HOLDOFF (HOLDOFF)
    ) u_ch (
      .sclock     (sclock),
      .rst        (rst),
      .load_en    (load_en),
      .load_delay (load.load_delay),
      .load_pw    (load.load_pw),
      .load_mode  (load.load_mode),
      .arm        (arm[g]),
      .abort      (abort[g]),
      .trigger    (trigger[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .state_dbg  (state_dbg[g])
    );
  end

endmodule

// File: tb/tb_qpd_multi.sv
// Self-checking bench for qpd_multi: expected pulses/done events queued at arm time, checked by a monitor.
module tb_qpd_multi;
  import qpd_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int PW_W    = 8;
  localparam int HOLDOFF = 100;

  logic              sclock = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] arm, abort;
  logic [NUM_CH-1:0] trigger, busy, done;
  qpd_state_t        state_dbg [NUM_CH];

  qpd_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PW_W(PW_W)) lif ();

  qpd_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PW_W(PW_W), .HOLDOFF(HOLDOFF)) dut (
    .sclock    (sclock),
    .rst       (rst),
    .load      (lif),
    .arm       (arm),
    .abort     (abort),
    .trigger   (trigger),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 sclock = ~sclock;

  int cyc = 0;
  always @(posedge sclock) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- scoreboard ----------------
  // exp_q entry: {ch, rise edge, width}; done_q entry: {ch, edge}
  logic [39:0] exp_q[$];
  logic [31:0] done_q[$];

  function automatic int eff_d(input int d);
    int v;
    v = (d == 0) ? 1 : d;
`ifdef QPD_HOLDOFF_EN
    if (v < HOLDOFF) v = HOLDOFF;
`endif
    return v;
  endfunction

  function automatic int eff_p(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic push_pulse(input int ch, input int rise, input int width);
    exp_q.push_back({8'(ch), 24'(rise), 8'(width)});
  endtask

  task automatic push_done(input int ch, input int e);
    done_q.push_back({8'(ch), 24'(e)});
  endtask

  logic [NUM_CH-1:0] prev_trig = '0;
  int                rise_at [NUM_CH];

  always @(posedge sclock) begin
    logic [39:0] e;
    logic [39:0] got;
    logic [31:0] d;
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (trigger[i] && !prev_trig[i]) rise_at[i] = cyc;
      if (!trigger[i] && prev_trig[i]) begin
        got = {8'(i), 24'(rise_at[i]), 8'(cyc - rise_at[i])};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL trig_unexpected ch=%0d rise=%0d width=%0d, required no pulse",
                   i, rise_at[i], cyc - rise_at[i]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            miscompares++;
            $display("FAIL trig_pulse got ch=%0d rise=%0d width=%0d, required ch=%0d rise=%0d width=%0d",
                     i, rise_at[i], cyc - rise_at[i], e[39:32], e[31:8], e[7:0]);
          end
        end
      end
      if (done[i]) begin
        vectors++;
        if (done_q.size() == 0) begin
          miscompares++;
          $display("FAIL done_unexpected ch=%0d edge=%0d, required no done", i, cyc);
        end else begin
          d = done_q.pop_front();
          if ({8'(i), 24'(cyc)} !== d) begin
            miscompares++;
            $display("FAIL done_pulse got ch=%0d edge=%0d, required ch=%0d edge=%0d",
                     i, cyc, d[31:24], d[23:0]);
          end
        end
      end
    end
    prev_trig = trigger;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge sclock);
      #1;
    end
  endtask

  task automatic strobe(input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] ab, output int k);
    @(negedge sclock);
    arm   = a;
    abort = ab;
    @(posedge sclock);
    #1;
    k = cyc;
    @(negedge sclock);
    arm   = '0;
    abort = '0;
  endtask

  task automatic do_load(input int ch, input int d, input int p, input logic mode, output logic acc);
    @(negedge sclock);
    lif.load_valid = 1'b1;
    lif.load_ch    = 2'(ch);
    lif.load_delay = CNT_W'(d);
    lif.load_pw    = PW_W'(p);
    lif.load_mode  = mode;
    #1;
    acc = lif.load_ready;
    @(negedge sclock);
    lif.load_valid = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    arm = '0;
    abort = '0;
    lif.load_valid = 1'b0;
    lif.load_ch    = '0;
    lif.load_delay = '0;
    lif.load_pw    = '0;
    lif.load_mode  = 1'b0;
    repeat (3) @(negedge sclock);
    rst = 1'b0;
    repeat (2) @(negedge sclock);
    chk("reset_trigger", int'(trigger), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_load_ready", int'(lif.load_ready), 1);
    chk("reset_state_ch0", int'(state_dbg[0]), int'(IDLE));
  endtask

  task automatic test_oneshot();
    logic acc;
    int k, dd;
    do_load(0, 5, 3, QPD_ONESHOT, acc);
    chk("oneshot_load_acc", int'(acc), 1);
    dd = eff_d(5);
    strobe(4'b0001, 4'b0000, k);
    push_pulse(0, k + dd, 3);
    push_done(0, k + dd + 3);
    chk("oneshot_busy_at_arm", int'(busy[0]), 1);
    wait_cyc(k + dd + 2);
    chk("oneshot_busy_last", int'(busy[0]), 1);
    chk("oneshot_trig_last", int'(trigger[0]), 1);
    wait_cyc(k + dd + 3);
    chk("oneshot_busy_end", int'(busy[0]), 0);
    chk("oneshot_trig_end", int'(trigger[0]), 0);
  endtask

  task automatic test_stale();
    logic acc;
    int k, dd;
    strobe(4'b0001, 4'b0000, k);
    for (int i = 0; i < 6; i++) begin
      chk("stale_busy", int'(busy[0]), 0);
      @(negedge sclock);
    end
    do_load(0, 2, 2, QPD_ONESHOT, acc);
    chk("stale_reload_acc", int'(acc), 1);
    dd = eff_d(2);
    strobe(4'b0001, 4'b0000, k);
    push_pulse(0, k + dd, 2);
    push_done(0, k + dd + 2);
    wait_cyc(k + dd + 3);
    chk("stale_rearm_idle", int'(busy[0]), 0);
  endtask

  task automatic test_periodic();
    logic acc;
    int k, ka, dd, last;
    do_load(1, 4, 2, QPD_PERIODIC, acc);
    chk("periodic_load_acc", int'(acc), 1);
    dd = eff_d(4);
    strobe(4'b0010, 4'b0000, k);
    push_pulse(1, k + dd, 2);
    push_pulse(1, k + 2 * dd + 2, 2);
    last = k + 3 * dd + 4;
    push_pulse(1, last, 1);  // abort lands one edge into the third pulse
    wait_cyc(last);
    chk("periodic_busy_third", int'(busy[1]), 1);
    strobe(4'b0000, 4'b0010, ka);
    chk("periodic_abort_edge", ka, last + 1);
    chk("periodic_trig_after_abort", int'(trigger[1]), 0);
    chk("periodic_busy_after_abort", int'(busy[1]), 0);
    strobe(4'b0010, 4'b0000, k);
    repeat (3) @(negedge sclock);
    chk("periodic_stale_after_abort", int'(busy[1]), 0);
  endtask

  task automatic test_boundary();
    logic acc;
    int k, dd;
    do_load(2, 0, 0, QPD_ONESHOT, acc);
    chk("zero_load_acc", int'(acc), 1);
    dd = eff_d(0);
    strobe(4'b0100, 4'b0000, k);
    push_pulse(2, k + dd, eff_p(0));
    push_done(2, k + dd + 1);
    wait_cyc(k + dd + 2);
    // load into a busy channel must bounce and leave the running sequence intact
    do_load(2, 50, 4, QPD_ONESHOT, acc);
    dd = eff_d(50);
    strobe(4'b0100, 4'b0000, k);
    push_pulse(2, k + dd, 4);
    push_done(2, k + dd + 4);
    do_load(2, 3, 1, QPD_PERIODIC, acc);
    chk("busy_load_ready", int'(acc), 0);
    wait_cyc(k + dd + 5);
    chk("busy_load_oneshot_kept", int'(busy[2]), 0);
    // arm and abort together: stays idle, parameters stay fresh
    do_load(3, 2, 1, QPD_ONESHOT, acc);
    strobe(4'b1000, 4'b1000, k);
    chk("arm_abort_busy", int'(busy[3]), 0);
    repeat (3) @(negedge sclock);
    chk("arm_abort_trig", int'(trigger[3]), 0);
    dd = eff_d(2);
    strobe(4'b1000, 4'b0000, k);
    push_pulse(3, k + dd, 1);
    push_done(3, k + dd + 1);
    wait_cyc(k + dd + 2);
  endtask

  task automatic test_concurrency();
    logic acc;
    int k, k2, d3;
    for (int i = 0; i < NUM_CH; i++) begin
      do_load(i, 3 * (i + 1), 1, QPD_ONESHOT, acc);
      chk("conc_load_acc", int'(acc), 1);
    end
    d3 = eff_d(12);
    strobe(4'b1111, 4'b0000, k);
    for (int i = 0; i < NUM_CH; i++) push_pulse(i, k + eff_d(3 * (i + 1)), 1);
    for (int i = 0; i < NUM_CH - 1; i++)
      if (eff_d(3 * (i + 1)) < d3) push_done(i, k + eff_d(3 * (i + 1)) + 1);
    chk("conc_busy_all", int'(busy), 15);
    wait_cyc(k + d3);
    chk("conc_ch3_trig", int'(trigger[3]), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_trigger_async", int'(trigger), 0);
    chk("rst_busy_async", int'(busy), 0);
    chk("rst_done_async", int'(done), 0);
    repeat (2) @(negedge sclock);
    rst = 1'b0;
    strobe(4'b0001, 4'b0000, k2);
    repeat (4) @(negedge sclock);
    chk("post_rst_stale_arm", int'(busy[0]), 0);
  endtask

  task automatic test_holdoff();
    logic acc;
    int k, dd;
    do_load(0, 10, 1, QPD_ONESHOT, acc);
    chk("holdoff_load_acc", int'(acc), 1);
`ifdef QPD_HOLDOFF_EN
    dd = HOLDOFF;
`else
    dd = 10;
`endif
    strobe(4'b0001, 4'b0000, k);
    push_pulse(0, k + dd, 1);
    push_done(0, k + dd + 1);
    wait_cyc(k + dd - 1);
    chk("holdoff_trig_before", int'(trigger[0]), 0);
    wait_cyc(k + dd);
    chk("holdoff_trig_at", int'(trigger[0]), 1);
    wait_cyc(k + dd + 2);
  endtask

  initial begin
    int budget;
    test_reset();
    test_oneshot();
    test_stale();
    test_periodic();
    test_boundary();
    test_concurrency();
    test_holdoff();
    budget = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && budget < 300) begin
      @(negedge sclock);
      budget++;
    end
    chk("pulses_outstanding", exp_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
